vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Produces the raster scan that the per-piece sprite renderers and board compositor consume: DrawX, DrawY, blank, hsync and vsync.
- Default timing is 640x480 at 60 Hz from a 25 MHz pixel clock.
- Sits at the top of the video path. Drives every sprite block's DrawX/DrawY/blank inputs and the board's VGA pins.
- blank follows the sprite renderers' convention: 1 = visible pixel, so colour is emitted.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch in pixels
- H_SYNC, 96, horizontal sync width in pixels
- H_BACK, 48, horizontal back porch in pixels
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch in lines
- V_SYNC, 2, vertical sync width in lines
- V_BACK, 33, vertical back porch in lines

Ports:
- vga_clk, input, 1, pixel clock; all logic on posedge
- reset_n, input, 1, synchronous active-low reset
- DrawX, output, 10, current horizontal counter, 0..H_TOTAL-1
- DrawY, output, 10, current vertical counter, 0..V_TOTAL-1
- blank, output, 1, 1 when DrawX<H_VISIBLE and DrawY<V_VISIBLE
- hs, output, 1, horizontal sync, active low
- vs, output, 1, vertical sync, active low
- frame_start, output, 1, one-cycle pulse at DrawX=0, DrawY=0
- line_start, output, 1, one-cycle pulse at DrawX=0 on every line

Behaviour:
- Derived totals: H_TOTAL = sum of the four H_* parameters (800). V_TOTAL = sum of the four V_* parameters (525).
- Reset (reset_n=0 sampled at a posedge):
  - DrawX=0, DrawY=0, blank=0, hs=1, vs=1, frame_start=0, line_start=0.
  - Values hold for as long as reset_n stays low.
- Counting, each posedge with reset_n=1:
  - DrawX increments.
  - At DrawX=H_TOTAL-1, DrawX wraps to 0 and DrawY increments.
  - At DrawX=H_TOTAL-1 and DrawY=V_TOTAL-1, both wrap to 0.
- Registered decode: hs, vs, blank, frame_start and line_start are registers computed from the next counter values, so every output matches the DrawX/DrawY present in the same cycle. Latency from counter to decode is 0.
- Decode rules:
  - hs=0 iff H_VISIBLE+H_FRONT <= DrawX < H_VISIBLE+H_FRONT+H_SYNC (656..751).
  - vs=0 iff V_VISIBLE+V_FRONT <= DrawY < V_VISIBLE+V_FRONT+V_SYNC (490..491), for the whole line.
  - blank=1 iff DrawX<640 and DrawY<480.
  - frame_start=1 iff DrawX=0 and DrawY=0.
  - line_start=1 iff DrawX=0.
- First cycle after reset release: counters go to (1,0) and blank=1. Pixel (0,0) of the first frame is therefore never presented, and there is no frame_start until the first wrap. This is accepted.
- Reset mid-frame: the next posedge forces the reset state regardless of counter position. No partial sync pulse may persist; hs and vs go to 1 on that edge.
- Counters are 10 bits wide. Parameter sets with H_TOTAL or V_TOTAL above 1024 are unsupported. An elaboration-time assertion flags them.
- No combinational path from any input to any output.

Optional Feature:
- Macro: VGA_SYNC_ALIGN_EN.
- Defined:
  - hs, vs and blank get one extra register stage (reset values 1, 1, 0). This matches the one-cycle registered colour output of the sprite renderers.
  - DrawX/DrawY are not delayed, so the renderers still address their ROMs one cycle early.
  - frame_start and line_start are not delayed.
- Not defined: hs, vs and blank are aligned with DrawX/DrawY exactly as described in Behaviour.

Test Plan:
- Reset held 10 cycles, then released:
  - During reset: DrawX=0, DrawY=0, hs=1, vs=1, blank=0.
  - First active edge: DrawX=1, blank=1.
- Run one line:
  - DrawX=639 gives blank=1; DrawX=640 gives blank=0.
  - hs=0 for exactly 96 cycles, starting at DrawX=656.
  - After DrawX=799, DrawX=0 and DrawY increments.
  - line_start=1 only at DrawX=0.
- Run one full frame (420000 cycles):
  - vs=0 for exactly 1600 cycles, covering DrawY=490..491.
  - DrawY wraps 524->0.
  - frame_start pulses exactly once per 420000 cycles.
- Count blank=1 cycles over one full frame -> exactly 307200.
- Assert reset_n=0 at DrawX=700, DrawY=491, while both syncs are low:
  - Next edge: hs=1, vs=1, counters at 0.
  - After release, counting restarts from (1,0).
- With VGA_SYNC_ALIGN_EN defined: hs falls when DrawX=657 (not 656), and blank falls when DrawX=641; DrawX sequence is unchanged.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Raster timing generator: DrawX/DrawY counters with registered sync/blank decode, 640x480@60 by default.
// Optional macro VGA_SYNC_ALIGN_EN delays hs/vs/blank one cycle to line up with registered sprite colour.
module vga_timing_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic       vga_clk,
   input  logic       reset_n,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       blank,
   output logic       hs,
   output logic       vs,
   output logic       frame_start,
   output logic       line_start
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
   // 11-bit bounds so a sync window ending exactly at 1024 still compares correctly
   localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
   localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
   localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FRONT);
   localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [10:0] VS_BEG = 11'(V_VISIBLE + V_FRONT);
   localparam logic [10:0] VS_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);

   generate
      if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_timing
         $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 10-bit counter range");
      end
   endgenerate

   logic [9:0]  x_nxt;
   logic [9:0]  y_nxt;
   logic [10:0] x_ext;
   logic [10:0] y_ext;
   logic        hs_r;
   logic        vs_r;
   logic        blank_r;

   always_comb begin
      x_nxt = DrawX + 10'd1;
      y_nxt = DrawY;
      if (DrawX == H_LAST) begin
         x_nxt = '0;
         if (DrawY == V_LAST) y_nxt = '0;
         else                 y_nxt = DrawY + 10'd1;
      end
      x_ext = {1'b0, x_nxt};
      y_ext = {1'b0, y_nxt};
   end

   // Decode from the next counter values so outputs line up with the counters they accompany
   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         DrawX       <= '0;
         DrawY       <= '0;
         hs_r        <= 1'b1;
         vs_r        <= 1'b1;
         blank_r     <= 1'b0;
         frame_start <= 1'b0;
         line_start  <= 1'b0;
      end else begin
         DrawX       <= x_nxt;
         DrawY       <= y_nxt;
         hs_r        <= !((x_ext >= HS_BEG) && (x_ext < HS_END));
         vs_r        <= !((y_ext >= VS_BEG) && (y_ext < VS_END));
         blank_r     <= (x_ext < H_VIS) && (y_ext < V_VIS);
         frame_start <= (x_nxt == 10'd0) && (y_nxt == 10'd0);
         line_start  <= (x_nxt == 10'd0);
      end
   end

`ifdef VGA_SYNC_ALIGN_EN
   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         hs    <= 1'b1;
         vs    <= 1'b1;
         blank <= 1'b0;
      end else begin
         hs    <= hs_r;
         vs    <= vs_r;
         blank <= blank_r;
      end
   end
`else
   assign hs    = hs_r;
   assign vs    = vs_r;
   assign blank = blank_r;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: full 800-pixel lines with a shortened frame (29 lines) to keep runtime small.
module tb_vga_timing_gen;

`ifdef VGA_SYNC_ALIGN_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   localparam int HT  = 800;
   localparam int VT  = 29;     // 20 visible + 3 front + 2 sync + 4 back
   localparam int VVI = 20;

   logic       vga_clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [9:0] DrawX;
   logic [9:0] DrawY;
   logic       blank;
   logic       hs;
   logic       vs;
   logic       frame_start;
   logic       line_start;

   int total = 0;
   int bad   = 0;

   int exp_x  = 0;
   int exp_y  = 0;
   int prev_x = 0;
   int prev_y = 0;

   vga_timing_gen #(
      .H_VISIBLE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
      .V_VISIBLE(20),  .V_FRONT(3),  .V_SYNC(2),  .V_BACK(4)
   ) dut (
      .vga_clk(vga_clk),
      .reset_n(reset_n),
      .DrawX(DrawX),
      .DrawY(DrawY),
      .blank(blank),
      .hs(hs),
      .vs(vs),
      .frame_start(frame_start),
      .line_start(line_start)
   );

   always #20 vga_clk = ~vga_clk;

   // Advance one edge, then update the reference position; outputs are sampled 1 ns after the edge
   task automatic tick();
      logic r;
      r = reset_n;
      @(posedge vga_clk);
      #1;
      prev_x = exp_x;
      prev_y = exp_y;
      if (!r) begin
         exp_x = 0;
         exp_y = 0;
      end else if (exp_x == HT - 1) begin
         exp_x = 0;
         exp_y = (exp_y == VT - 1) ? 0 : exp_y + 1;
      end else begin
         exp_x = exp_x + 1;
      end
   endtask

   function automatic logic ref_hs(int x);
      return !(x >= 656 && x < 752);
   endfunction

   function automatic logic ref_vs(int y);
      return !(y >= 23 && y < 25);
   endfunction

   function automatic logic ref_blank(int x, int y);
      return (x < 640) && (y < VVI);
   endfunction

   task automatic test_reset();
      int err;
      err = 0;
      reset_n = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (DrawX !== 10'd0 || DrawY !== 10'd0 || hs !== 1'b1 || vs !== 1'b1 ||
             blank !== 1'b0 || frame_start !== 1'b0 || line_start !== 1'b0)
            err++;
      end
      total++;
      if (err !== 0) begin
         bad++;
         $display("FAIL reset_hold: %0d bad cycles (x=%0d y=%0d hs=%b vs=%b blank=%b), need 0", err, DrawX, DrawY, hs, vs, blank);
      end
      reset_n = 1'b1;
      tick();
      total++;
      if (DrawX !== 10'd1 || DrawY !== 10'd0) begin
         bad++;
         $display("FAIL first_edge_pos: got (%0d,%0d) need (1,0)", DrawX, DrawY);
      end
      total++;
      if (blank !== (ALIGN ? 1'b0 : 1'b1)) begin
         bad++;
         $display("FAIL first_edge_blank: got %b need %b", blank, !ALIGN);
      end
      total++;
      if (hs !== 1'b1 || vs !== 1'b1 || line_start !== 1'b0 || frame_start !== 1'b0) begin
         bad++;
         $display("FAIL first_edge_flags: hs=%b vs=%b ls=%b fs=%b need 1 1 0 0", hs, vs, line_start, frame_start);
      end
   endtask

   task automatic test_line();
      int pos_err, ls_err, hs_low, hs_fall_x, ls_cnt;
      logic b_hi, b_lo;
      pos_err = 0; ls_err = 0; hs_low = 0; hs_fall_x = -1; ls_cnt = 0;
      b_hi = 1'bx; b_lo = 1'bx;
      for (int i = 0; i < HT - 1; i++) begin
         tick();
         if (DrawX !== 10'(exp_x) || DrawY !== 10'(exp_y)) pos_err++;
         if (line_start !== (exp_x == 0)) ls_err++;
         if (line_start === 1'b1) ls_cnt++;
         if (hs === 1'b0) begin
            if (hs_fall_x < 0) hs_fall_x = int'(DrawX);
            hs_low++;
         end
         if (exp_x == (ALIGN ? 640 : 639)) b_hi = blank;
         if (exp_x == (ALIGN ? 641 : 640)) b_lo = blank;
      end
      total++;
      if (pos_err !== 0) begin
         bad++;
         $display("FAIL line_count_seq: %0d position errors, need 0", pos_err);
      end
      total++;
      if (b_hi !== 1'b1 || b_lo !== 1'b0) begin
         bad++;
         $display("FAIL line_blank_edge: got %b then %b, need 1 then 0", b_hi, b_lo);
      end
      total++;
      if (hs_low !== 96) begin
         bad++;
         $display("FAIL hs_width: got %0d cycles low, need 96", hs_low);
      end
      total++;
      if (hs_fall_x !== (ALIGN ? 657 : 656)) begin
         bad++;
         $display("FAIL hs_fall_x: got %0d need %0d", hs_fall_x, ALIGN ? 657 : 656);
      end
      total++;
      if (DrawX !== 10'd0 || DrawY !== 10'd1) begin
         bad++;
         $display("FAIL line_wrap: got (%0d,%0d) need (0,1)", DrawX, DrawY);
      end
      total++;
      if (ls_err !== 0 || ls_cnt !== 1) begin
         bad++;
         $display("FAIL line_start: %0d mismatched cycles, %0d pulses, need 0 and 1", ls_err, ls_cnt);
      end
   endtask

   task automatic test_frame();
      int pos_err, dec_err, fs_err, vs_low, blank_hi, fs_cnt, wrap_cnt, dx, dy;
      pos_err = 0; dec_err = 0; fs_err = 0; vs_low = 0; blank_hi = 0; fs_cnt = 0; wrap_cnt = 0;
      for (int i = 0; i < HT * VT; i++) begin
         tick();
         dx = ALIGN ? prev_x : exp_x;
         dy = ALIGN ? prev_y : exp_y;
         if (DrawX !== 10'(exp_x) || DrawY !== 10'(exp_y)) pos_err++;
         if (hs !== ref_hs(dx) || vs !== ref_vs(dy) || blank !== ref_blank(dx, dy)) dec_err++;
         if (frame_start !== (exp_x == 0 && exp_y == 0)) fs_err++;
         if (vs === 1'b0) vs_low++;
         if (blank === 1'b1) blank_hi++;
         if (frame_start === 1'b1) fs_cnt++;
         if (prev_y == VT - 1 && DrawY === 10'd0) wrap_cnt++;
      end
      total++;
      if (pos_err !== 0) begin
         bad++;
         $display("FAIL frame_count_seq: %0d position errors, need 0", pos_err);
      end
      total++;
      if (dec_err !== 0) begin
         bad++;
         $display("FAIL frame_decode: %0d hs/vs/blank errors, need 0", dec_err);
      end
      total++;
      if (vs_low !== 2 * HT) begin
         bad++;
         $display("FAIL vs_width: got %0d cycles low, need %0d", vs_low, 2 * HT);
      end
      total++;
      if (blank_hi !== 640 * VVI) begin
         bad++;
         $display("FAIL blank_count: got %0d need %0d", blank_hi, 640 * VVI);
      end
      total++;
      if (fs_cnt !== 1 || fs_err !== 0) begin
         bad++;
         $display("FAIL frame_start: got %0d pulses with %0d misplaced, need 1 and 0", fs_cnt, fs_err);
      end
      total++;
      if (wrap_cnt !== 1) begin
         bad++;
         $display("FAIL y_wrap: got %0d wraps 28->0, need 1", wrap_cnt);
      end
   endtask

   task automatic test_reset_mid();
      int guard;
      guard = 0;
      while (!(exp_x == 700 && exp_y == 24) && guard < HT * VT + 10) begin
         tick();
         guard++;
      end
      total++;
      if (DrawX !== 10'd700 || DrawY !== 10'd24 || hs !== 1'b0 || vs !== 1'b0) begin
         bad++;
         $display("FAIL mid_setup: got x=%0d y=%0d hs=%b vs=%b need 700 24 0 0", DrawX, DrawY, hs, vs);
      end
      reset_n = 1'b0;
      tick();
      total++;
      if (hs !== 1'b1 || vs !== 1'b1) begin
         bad++;
         $display("FAIL mid_reset_sync: got hs=%b vs=%b need 1 1", hs, vs);
      end
      total++;
      if (DrawX !== 10'd0 || DrawY !== 10'd0 || blank !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset_pos: got (%0d,%0d) blank=%b need (0,0) 0", DrawX, DrawY, blank);
      end
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      total++;
      if (DrawX !== 10'd1 || DrawY !== 10'd0) begin
         bad++;
         $display("FAIL mid_restart: got (%0d,%0d) need (1,0)", DrawX, DrawY);
      end
      tick();
      total++;
      if (DrawX !== 10'd2 || blank !== 1'b1 || hs !== 1'b1) begin
         bad++;
         $display("FAIL mid_resume: got x=%0d blank=%b hs=%b need 2 1 1", DrawX, blank, hs);
      end
   endtask

   initial begin
      test_reset();
      test_line();
      test_frame();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
